// File: rtl/recon_block_scheduler.sv
// recon_block_scheduler
// Raster-order sequencer between the reconstruction pipeline and the frame
// assembler. One block is accepted per handshake, tagged with the next raster
// block coordinate, and handed to the assembler with a one-cycle start pulse.
// The next block is not accepted until the assembler reports done.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | no frame active, waiting for frame_start
//   S_WAIT_BLK  | blk_ready high, waiting for an upstream block
//   S_ISSUE     | asm_start pulse, coordinates already presented
//   S_WAIT_DONE | assembler working, timeout timer running
//   S_FRAME_END | frame_done pulse after the last block of the frame
//   S_FAULT     | assembler timed out, waiting for frame_start
module recon_block_scheduler #(
  parameter int BLOCKS_X       = 80,
  parameter int BLOCKS_Y       = 60,
  parameter int COORD_WIDTH    = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic                   asm_start,
  output logic [COORD_WIDTH-1:0] asm_block_x,
  output logic [COORD_WIDTH-1:0] asm_block_y,
  input  logic                   asm_done,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   restart_err
);

  // Timer counts down the remaining WAIT_DONE cycles; zero is the terminal count.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]          TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]          TMR_ONE  = TW'(1);
  localparam logic [COORD_WIDTH-1:0] X_LAST   = COORD_WIDTH'(BLOCKS_X - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST   = COORD_WIDTH'(BLOCKS_Y - 1);
  localparam logic [COORD_WIDTH-1:0] C_ONE    = COORD_WIDTH'(1);
  localparam logic [COORD_WIDTH-1:0] C_ZERO   = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_ISSUE,
    S_WAIT_DONE,
    S_FRAME_END,
    S_FAULT
  } state_t;

  state_t                   state_q, state_d;
  logic [COORD_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic                     terr_q, terr_d, rerr_q, rerr_d;

  // State, coordinate, timer and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tmr_q   <= '0;
      terr_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tmr_q   <= tmr_d;
      terr_q  <= terr_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state, coordinate advance and handshake/pulse outputs.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    tmr_d      = tmr_q;
    terr_d     = terr_q;
    rerr_d     = rerr_q;
    blk_ready  = 1'b0;
    asm_start  = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE, S_FAULT: begin
        if (frame_start) begin
          state_d = S_WAIT_BLK;
          x_d     = C_ZERO;
          y_d     = C_ZERO;
          terr_d  = 1'b0;
          rerr_d  = 1'b0;
        end
      end
      S_WAIT_BLK: begin
        blk_ready = 1'b1;
        if (frame_start) begin
          state_d = S_WAIT_BLK;
          x_d     = C_ZERO;
          y_d     = C_ZERO;
          rerr_d  = 1'b1;
        end else if (blk_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        asm_start = 1'b1;
        if (frame_start) begin
          state_d = S_WAIT_BLK;
          x_d     = C_ZERO;
          y_d     = C_ZERO;
          rerr_d  = 1'b1;
        end else begin
          state_d = S_WAIT_DONE;
          tmr_d   = TMR_LOAD;
        end
      end
      S_WAIT_DONE: begin
        if (frame_start) begin
          state_d = S_WAIT_BLK;
          x_d     = C_ZERO;
          y_d     = C_ZERO;
          rerr_d  = 1'b1;
        end else if (asm_done) begin
          // Last block goes straight back to (0,0) so y never steps past the frame.
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = S_FRAME_END;
            x_d     = C_ZERO;
            y_d     = C_ZERO;
          end else begin
            state_d = S_WAIT_BLK;
            if (x_q == X_LAST) begin
              x_d = C_ZERO;
              y_d = y_q + C_ONE;
            end else begin
              x_d = x_q + C_ONE;
            end
          end
        end else if (tmr_q == '0) begin
          state_d = S_FAULT;
          terr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      S_FRAME_END: begin
        frame_done = 1'b1;
        x_d        = C_ZERO;
        y_d        = C_ZERO;
        if (frame_start) begin
          state_d = S_WAIT_BLK;
          rerr_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign asm_block_x = x_q;
  assign asm_block_y = y_q;
  assign timeout_err = terr_q;
  assign restart_err = rerr_q;

endmodule
